// File: rtl/inst_fetch_unit_pkg.sv
// Shared types for the instruction fetch unit: the NOP filler word, the fetch FSM
// states and the {pc, inst} entry carried through the output buffer.
package inst_fetch_unit_pkg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    DISCARD
  } ifu_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_unit_fetch_fifo.sv
// Synchronous FIFO of fetch entries; push and pop may occur in the same cycle even
// when full, and flush empties it in one cycle.
module fetch_fifo
  import inst_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  fetch_entry_t                 entry_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  output fetch_entry_t                 head_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (count == '0);
  assign full_o  = (count == CW'(DEPTH));
  assign count_o = count;
  assign head_o  = mem[rd_ptr];

  // A slot freed by a same-cycle pop makes room for a push into a full buffer.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // NOTE: the storage array is deliberately not reset; only pointers and count are,
  // since an entry is never read before it has been written.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem[wr_ptr] <= entry_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: one-outstanding req/gnt/rvalid fetch into a small buffer
// feeding decode. Optional perf counters enabled by macro IFU_PERF_CNT_EN.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic        inst_valid_o,
  input  logic        inst_ready_i
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] flush_cnt_o
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  ifu_state_e   state;
  logic [31:0]  fetch_pc;
  logic [31:0]  req_pc;
  logic         granted;
  logic         fifo_push;
  logic         fifo_pop;
  logic         fifo_full;
  logic         fifo_empty;
  logic [CW-1:0] fifo_count;
  fetch_entry_t head;

  // Nothing is outstanding while in REQ, so buffer occupancy alone bounds the request.
  assign imem_req_o  = !rst_i && (state == REQ) && (fifo_count < CW'(FIFO_DEPTH));
  assign imem_addr_o = fetch_pc;
  assign granted     = imem_req_o && imem_gnt_i;

  assign fifo_push = !rst_i && !redirect_i && (state == WAIT) && imem_rvalid_i &&
                     (!fifo_full || fifo_pop);
  assign fifo_pop  = inst_valid_o && inst_ready_i;

  assign inst_valid_o = !fifo_empty;
  assign inst_o       = fifo_empty ? NOP   : head.inst;
  assign pc_o         = fifo_empty ? '0    : head.pc;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .entry_i ('{pc: req_pc, inst: imem_rdata_i}),
    .pop_i   (fifo_pop),
    .flush_i (redirect_i),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // NOTE: non-blocking assignments so every register samples pre-edge values and
  // the order of statements inside the block does not matter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= REQ;
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
    end else if (redirect_i) begin
      fetch_pc <= redirect_pc_i & 32'hFFFF_FFFC;
      unique case (state)
        REQ:           state <= granted ? DISCARD : REQ;
        WAIT, DISCARD: state <= imem_rvalid_i ? REQ : DISCARD;
        default:       state <= REQ;
      endcase
    end else begin
      unique case (state)
        REQ: begin
          if (granted) begin
            fetch_pc <= fetch_pc + 32'd4;
            req_pc   <= fetch_pc;
            state    <= WAIT;
          end
        end
        WAIT, DISCARD: begin
          if (imem_rvalid_i) state <= REQ;
        end
        default: state <= REQ;
      endcase
    end
  end

`ifdef IFU_PERF_CNT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (fifo_push)  fetch_cnt_o <= fetch_cnt_o + 32'd1;
      if (redirect_i) flush_cnt_o <= flush_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
Producer end of the instruction interface consumed by the decode/control logic. Holds the fetch PC, issues word reads to instruction memory over a req/gnt/rvalid handshake, and buffers returned words with their PC. Presents them to decode over a valid/ready interface. Handles redirects from branch/jump resolution by flushing in-flight and buffered instructions.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset; bits [1:0] must be 0
FIFO_DEPTH, 2, entries in the output buffer; power of two, at least 2

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; synchronous, active-high
imem_req_o  out  1  fetch request valid
imem_addr_o  out  32  word-aligned fetch address
imem_gnt_i  in  1  memory accepts request this cycle
imem_rvalid_i  in  1  read data valid
imem_rdata_i  in  32  instruction word
redirect_i  in  1  change fetch stream
redirect_pc_i  in  32  new fetch address
inst_o  out  32  instruction to decode
pc_o  out  32  PC of inst_o
inst_valid_o  out  1  inst_o/pc_o valid
inst_ready_i  in  1  decode consumes the head entry

Behaviour:
- Reset is synchronous and active-high. On reset: fetch_pc=RESET_PC, FIFO empty, state REQ, imem_req_o=0 for the reset cycle, inst_valid_o=0, inst_o=32'h0000_0013 (NOP), pc_o=0.
- Outputs when the FIFO is empty: inst_o=NOP, pc_o=0.
- At most one outstanding memory request.
- State REQ:
  - imem_req_o=1 iff (FIFO count + 0 outstanding) < FIFO_DEPTH.
  - imem_addr_o=fetch_pc.
  - On req&gnt: fetch_pc+=4 (mod 2^32, wraps FFFF_FFFC to 0), captured addr saved as req_pc, go to WAIT.
- State WAIT:
  - imem_req_o=0.
  - On rvalid: push {req_pc, rdata} into the FIFO, go to REQ.
  - Space is guaranteed by the REQ condition.
- State DISCARD:
  - imem_req_o=0.
  - On rvalid: drop the data, go to REQ.
- Redirect (highest priority, in any state):
  - fetch_pc <= {redirect_pc_i[31:2],2'b00}.
  - FIFO cleared, so inst_valid_o=0 next cycle.
  - REQ without gnt: stay in REQ.
  - REQ with gnt the same cycle: granted request is stale, go to DISCARD.
  - WAIT without rvalid: go to DISCARD.
  - WAIT or DISCARD with rvalid the same cycle: data dropped, go to REQ.
  - DISCARD without rvalid: stay in DISCARD.
- Output side:
  - inst_valid_o = FIFO not empty and no redirect registered.
  - Head pops when inst_valid_o & inst_ready_i.
  - Push and pop in the same cycle are legal, including when the FIFO is full or has one entry.
- Latency: rvalid at cycle N gives inst_valid_o at N+1. With a 1-cycle memory and constant ready, throughput is 1 instruction per 2 cycles.
- Reset mid-transaction: FSM returns to REQ. A later stray rvalid arriving in REQ is ignored.
- Outputs stay stable while inst_valid_o=1 and inst_ready_i=0.

Optional Feature:
Macro IFU_PERF_CNT_EN.
- Defined: adds outputs fetch_cnt_o[31:0] (increments on every FIFO push) and flush_cnt_o[31:0] (increments on every redirect). Both reset to 0 and wrap.
- Undefined: ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package gets:
  - the NOP constant 32'h0000_0013;
  - enum ifu_state_e {REQ, WAIT, DISCARD};
  - packed struct fetch_entry_t {pc[31:0], inst[31:0]}.
- One sub-module: fetch_fifo. It is a synchronous FIFO of fetch_entry_t with push, pop, flush, full, empty and count, and simultaneous push/pop support.

Test Plan:
1. Reset, then gnt tied 1 and rvalid the cycle after gnt, ready=1 -> memory returns 0x00500093, 0x00A00113 for addresses 0x0, 0x4; decode sees those instructions in order with pc_o=0x0, 0x4.
2. ready=0 for 10 cycles -> at most FIFO_DEPTH entries accepted, imem_req_o drops to 0, and inst_o/pc_o stay stable. Then ready=1 -> the stream resumes with no loss or duplication.
3. Redirect to 0x0000_0103 while in WAIT, rvalid 2 cycles later -> that response is dropped, and the next imem_addr_o=0x0000_0100.
4. Redirect the same cycle as req&gnt, and separately the same cycle as rvalid -> neither the stale word nor any buffered word reaches decode, and the first new pc_o equals the redirect target.
5. rst_i asserted while in WAIT, then a stray rvalid -> imem_addr_o=RESET_PC, and the stray word is not enqueued.
6. fetch_pc=0xFFFF_FFFC -> the next fetch address is 0x0000_0000. With IFU_PERF_CNT_EN defined, fetch_cnt_o and flush_cnt_o match the push and redirect counts.
